// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Odd parity over data plus parity bit.
  function automatic logic ps2_par_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Key-event bus from the PS/2 receiver to the core (kstrobe/kpress/kcode).
interface ps2_receiver_if;
  logic       strobe;
  logic       pressed;
  logic [7:0] code;
  logic       extended;

  modport master (output strobe, pressed, code, extended);
  modport slave  (input  strobe, pressed, code, extended);
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus level filter for one raw PS/2 line (idle high).
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);
  localparam int CW = $clog2(FILTER + 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          w_s;

  assign w_s    = r_sync[1];
  assign o_filt = r_filt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // Output flips on the FILTER-th consecutive differing sample.
      if (w_s != r_filt) begin
        if (r_cnt == CW'(FILTER - 1)) begin
          r_filt <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with F0/E0 prefix decoding and frame timeout.
// Define PS2_PARITY_EN to reject frames failing odd parity.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ps2Ck,
  input  logic           ps2D,
  ps2_receiver_if.master kbd
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    w_filt;
  logic          w_ck, w_d;
  logic          r_ck_d, r_fall, r_smp;
  ps2_state_e    r_state, w_state_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic          r_brk, w_brk_n, r_ext, w_ext_n;
  logic [TW-1:0] r_to;
  logic          w_to_hit, w_frame_ok, w_emit;
  logic          r_strobe, r_pressed, r_extended;
  logic [7:0]    r_code;

  ps2_filter #(.FILTER(FILTER)) u_filt [1:0] (
    .clock  (clock),
    .reset  (reset),
    .i_raw  ({ps2D, ps2Ck}),
    .o_filt (w_filt)
  );

  assign w_ck = w_filt[0];
  assign w_d  = w_filt[1];

`ifdef PS2_PARITY_EN
  assign w_frame_ok = r_smp && ps2_par_ok(r_shift, r_par);
`else
  assign w_frame_ok = r_smp;
`endif

  assign w_to_hit = (r_state != IDLE) && (r_to == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_n    = r_par;
    w_brk_n    = r_brk;
    w_ext_n    = r_ext;
    w_emit     = 1'b0;
    // An edge in the expiry cycle takes priority over the timeout.
    if (r_fall) begin
      case (r_state)
        IDLE: if (!r_smp) begin
          w_state_n  = DATA;
          w_bitcnt_n = 3'd0;
        end
        DATA: begin
          w_shift_n = {r_smp, r_shift[7:1]};
          if (r_bitcnt == 3'd7) w_state_n = PARITY;
          else                  w_bitcnt_n = r_bitcnt + 3'd1;
        end
        PARITY: begin
          w_par_n   = r_smp;
          w_state_n = STOP;
        end
        STOP: begin
          w_state_n = IDLE;
          if (w_frame_ok) begin
            if (r_shift == PS2_BREAK)    w_brk_n = 1'b1;
            else if (r_shift == PS2_EXT) w_ext_n = 1'b1;
            else begin
              w_emit  = 1'b1;
              w_brk_n = 1'b0;
              w_ext_n = 1'b0;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end else if (w_to_hit) begin
      w_state_n  = IDLE;
      w_bitcnt_n = 3'd0;
      w_shift_n  = 8'h00;
      w_brk_n    = 1'b0;
      w_ext_n    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ck_d     <= 1'b1;
      r_fall     <= 1'b0;
      r_smp      <= 1'b1;
      r_state    <= IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      r_to       <= '0;
      r_strobe   <= 1'b0;
      r_pressed  <= 1'b0;
      r_code     <= 8'h00;
      r_extended <= 1'b0;
    end else begin
      r_ck_d   <= w_ck;
      r_fall   <= r_ck_d & ~w_ck;
      r_smp    <= w_d;
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_brk    <= w_brk_n;
      r_ext    <= w_ext_n;
      if (r_state == IDLE || r_fall) r_to <= '0;
      else                           r_to <= r_to + TW'(1);
      r_strobe <= w_emit;
      if (w_emit) begin
        r_code     <= r_shift;
        r_pressed  <= ~r_brk;
        r_extended <= r_ext;
      end
    end
  end

  assign kbd.strobe   = r_strobe;
  assign kbd.pressed  = r_pressed;
  assign kbd.code     = r_code;
  assign kbd.extended = r_extended;
endmodule
